// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IRQ     = 2'd1,
        EXC     = 2'd2,
        IRQ_EXC = 2'd3
    } irq_state_t;

    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
    localparam logic [31:0] MCAUSE_ILLEGAL = 32'h0000_0002;

    // Winner id width; a single-line controller still carries a 1-bit id.
    function automatic int irq_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_controller_vec_priority_enc.sv
// Fixed-priority encoder, lowest set index wins.
// Latency: combinational.
// Backpressure: none.
module irq_priority_enc
    import irq_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int IdW  = irq_id_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IdW-1:0]   id,
    output logic [WIDTH-1:0] grant
);

    always_comb begin
        valid = |req;
        id    = '0;
        grant = '0;
        // Walk from the top down so the lowest set index is the last write.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                id       = IdW'(i);
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller_vec.sv
// Multi-line interrupt controller: per-line enables, lowest-index priority, nesting FSM; IRQ_EDGE_EN selects edge-pending mode.
// Latency: irq_o/irq_cause_o/irq_ret_o combinational, irq_ack_o registered one cycle.
// Backpressure: stall_i holds off acceptance; requests wait (pending bit or held level).
module irq_controller_vec
    import irq_pkg::*;
#(
    parameter int          IRQ_NUM    = 16,
    parameter logic [31:0] CAUSE_BASE = IRQ_CAUSE_BASE
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stall_i,
    input  logic               exception_i,
    input  logic               mret_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [IRQ_NUM-1:0] mie_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic               irq_ret_o,
    output logic [IRQ_NUM-1:0] irq_ack_o
);

    localparam int IdW = irq_id_width(IRQ_NUM);

    irq_state_t         state_q, state_d;
    logic [IRQ_NUM-1:0] pending;
    logic [IRQ_NUM-1:0] cand;
    logic [IRQ_NUM-1:0] grant;
    logic [IRQ_NUM-1:0] ack_q;
    logic [IdW-1:0]     win_id;
    logic               cand_vld;
    logic               accept;
    logic               ret;

`ifdef IRQ_EDGE_EN
    logic [IRQ_NUM-1:0] req_q;
    logic [IRQ_NUM-1:0] pend_q;

    // A rising edge in the acceptance cycle re-arms the bit it clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q  <= '0;
            pend_q <= '0;
        end else begin
            req_q  <= irq_req_i;
            pend_q <= (pend_q & ~(grant & {IRQ_NUM{irq_o}})) | (irq_req_i & ~req_q);
        end
    end

    assign pending = pend_q;
`else
    assign pending = irq_req_i;
`endif

    assign cand = pending & mie_i;

    irq_priority_enc #(
        .WIDTH (IRQ_NUM)
    ) u_prio (
        .req   (cand),
        .valid (cand_vld),
        .id    (win_id),
        .grant (grant)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= grant & {IRQ_NUM{irq_o}};
        end
    end

    // mret takes precedence over a coincident exception; exceptions do not nest.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ret     = 1'b0;
        case (state_q)
            IDLE: begin
                if (exception_i) begin
                    state_d = EXC;
                end else if (!stall_i && cand_vld) begin
                    accept  = 1'b1;
                    state_d = IRQ;
                end
            end
            IRQ: begin
                if (mret_i) begin
                    ret     = 1'b1;
                    state_d = IDLE;
                end else if (exception_i) begin
                    state_d = IRQ_EXC;
                end
            end
            EXC: begin
                if (mret_i) state_d = IDLE;
            end
            IRQ_EXC: begin
                if (mret_i) state_d = IRQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Held reset silences the combinational outputs even if lines are active.
    assign irq_o       = rst_ni & accept;
    assign irq_ret_o   = rst_ni & ret;
    assign irq_cause_o = irq_o ? (CAUSE_BASE + 32'(win_id)) : 32'h0;
    assign irq_ack_o   = ack_q;

endmodule

// File: tb/tb_irq_controller_vec.sv
module tb_irq_controller_vec;
    import irq_pkg::*;

    localparam int N = 16;
`ifdef IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, exc, mret;
    logic [N-1:0]  req, mie;
    logic          irq_o, irq_ret_o;
    logic [31:0]   irq_cause_o;
    logic [N-1:0]  irq_ack_o;

    int n_cmp = 0;
    int n_err = 0;
    int tag   = 0;

    always #5 clk = ~clk;

    irq_controller_vec #(
        .IRQ_NUM    (N),
        .CAUSE_BASE (32'h8000_0010)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .stall_i     (stall),
        .exception_i (exc),
        .mret_i      (mret),
        .irq_req_i   (req),
        .mie_i       (mie),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o),
        .irq_ack_o   (irq_ack_o)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        exc;
        logic        mret;
        logic [15:0] req;
        logic [15:0] mie;
        logic        irq;
        logic [31:0] cause;
        logic        ret;
        logic [15:0] ack;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic st, input logic ex, input logic mr,
                                input logic [15:0] rq, input logic [15:0] me,
                                input logic ir, input logic [31:0] ca,
                                input logic rt, input logic [15:0] ak);
        vec_t v;
        v.rst_n = 1'b1; v.stall = st; v.exc = ex; v.mret = mr;
        v.req = rq; v.mie = me; v.irq = ir; v.cause = ca; v.ret = rt; v.ack = ak;
        return v;
    endfunction

    task automatic add(input logic st, input logic ex, input logic mr,
                       input logic [15:0] rq, input logic [15:0] me,
                       input logic ir, input logic [31:0] ca,
                       input logic rt, input logic [15:0] ak);
        tbl.push_back(mk(st, ex, mr, rq, me, ir, ca, rt, ak));
    endtask

    task automatic chk(input int t, input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL step %0d %s: got %h expected %h", t, nm, act, expv);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare on the falling edge.
    task automatic step(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rst_n = v.rst_n; stall = v.stall; exc = v.exc; mret = v.mret;
        req = v.req; mie = v.mie;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, "irq_o", 32'(irq_o), 32'(e.irq));
        chk(tag, "irq_cause_o", irq_cause_o, e.cause);
        chk(tag, "irq_ret_o", 32'(irq_ret_o), 32'(e.ret));
        chk(tag, "irq_ack_o", 32'(irq_ack_o), 32'(e.ack));
        tag++;
    endtask

    task automatic row(input logic st, input logic ex, input logic mr,
                       input logic [15:0] rq, input logic [15:0] me,
                       input logic ir, input logic [31:0] ca,
                       input logic rt, input logic [15:0] ak);
        step(mk(st, ex, mr, rq, me, ir, ca, rt, ak));
    endtask

    initial begin
        vec_t rv;
        logic [15:0] hold;

        rst_n = 1'b0; stall = 1'b0; exc = 1'b0; mret = 1'b0;
        req = '0; mie = '1;

        // Reset held with active enabled requests and mret: everything quiet.
        rv = mk(0, 0, 1, 16'h0088, 16'hFFFF, 0, 32'h0, 0, 16'h0);
        rv.rst_n = 1'b0;
        step(rv);
        step(rv);

        //   st ex mr req       mie       irq cause          ret ack
        if (EDGE) begin
            add(0, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 0, 16'h0088, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 0, 16'h0000, 16'hFFFF, 1, 32'h8000_0013, 0, 16'h0000);
            add(0, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0008);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0000);
            add(0, 0, 0, 16'h0000, 16'hFFFF, 1, 32'h8000_0017, 0, 16'h0000);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0080);
            add(0, 0, 0, 16'h0002, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 1, 0, 16'h0002, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 1, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 0, 16'h0000, 16'hFFFF, 1, 32'h8000_0011, 0, 16'h0000);
            add(0, 1, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0002);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 1, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0000);
            add(0, 0, 0, 16'h8001, 16'hFFFE, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 0, 16'h8001, 16'hFFFE, 1, 32'h8000_001F, 0, 16'h0000);
            add(0, 0, 1, 16'h0000, 16'hFFFE, 0, 32'h0,         1, 16'h8000);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 1, 32'h8000_0010, 0, 16'h0000);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0001);
            add(0, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            // New edge on the line being accepted keeps it pending.
            add(0, 0, 0, 16'h0010, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(1, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 0, 16'h0010, 16'hFFFF, 1, 32'h8000_0014, 0, 16'h0000);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0010);
            add(0, 0, 0, 16'h0000, 16'hFFFF, 1, 32'h8000_0014, 0, 16'h0000);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0010);
            add(0, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
        end else begin
            add(0, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 0, 16'h0088, 16'hFFFF, 1, 32'h8000_0013, 0, 16'h0000);
            add(0, 0, 0, 16'h0080, 16'hFFFF, 0, 32'h0,         0, 16'h0008);
            add(0, 0, 1, 16'h0080, 16'hFFFF, 0, 32'h0,         1, 16'h0000);
            add(0, 0, 0, 16'h0080, 16'hFFFF, 1, 32'h8000_0017, 0, 16'h0000);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0080);
            add(0, 1, 0, 16'h0002, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 1, 0, 16'h0002, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 1, 16'h0002, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 0, 0, 16'h0002, 16'hFFFF, 1, 32'h8000_0011, 0, 16'h0000);
            add(0, 1, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0002);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            add(0, 1, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0000);
            add(0, 0, 0, 16'h8001, 16'hFFFE, 1, 32'h8000_001F, 0, 16'h0000);
            add(0, 0, 1, 16'h8001, 16'hFFFE, 0, 32'h0,         1, 16'h8000);
            add(0, 0, 1, 16'h0001, 16'hFFFF, 1, 32'h8000_0010, 0, 16'h0000);
            add(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0001);
            add(0, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
        end

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Masked line waits ten cycles, then fires as soon as its enable is set.
        hold = EDGE ? 16'h0000 : 16'h0020;
        row(0, 0, 0, 16'h0020, 16'h0000, 0, 32'h0, 0, 16'h0);
        for (int i = 0; i < 10; i++) row(0, 0, 0, hold, 16'h0000, 0, 32'h0, 0, 16'h0);
        row(0, 0, 0, hold,     16'h0020, 1, 32'h8000_0015, 0, 16'h0000);
        row(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0020);

        // Four stalled cycles, then acceptance on the first free one.
        hold = EDGE ? 16'h0000 : 16'h0001;
        row(1, 0, 0, 16'h0001, 16'hFFFF, 0, 32'h0, 0, 16'h0);
        for (int i = 0; i < 3; i++) row(1, 0, 0, hold, 16'hFFFF, 0, 32'h0, 0, 16'h0);
        row(0, 0, 0, hold,     16'hFFFF, 1, 32'h8000_0010, 0, 16'h0000);
        row(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0,         1, 16'h0001);

        // Reset mid-handler with line 2 still outstanding.
        if (EDGE) begin
            row(0, 0, 0, 16'h0005, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            row(0, 0, 0, 16'h0000, 16'hFFFF, 1, 32'h8000_0010, 0, 16'h0000);
        end else begin
            row(0, 0, 0, 16'h0005, 16'hFFFF, 1, 32'h8000_0010, 0, 16'h0000);
            row(0, 0, 0, 16'h0004, 16'hFFFF, 0, 32'h0,         0, 16'h0001);
        end
        rv = mk(0, 0, 1, EDGE ? 16'h0000 : 16'h0004, 16'hFFFF, 0, 32'h0, 0, 16'h0);
        rv.rst_n = 1'b0;
        step(rv);
        for (int i = 0; i < 3; i++) row(0, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0, 0, 16'h0);
        if (EDGE) begin
            row(0, 0, 0, 16'h0004, 16'hFFFF, 0, 32'h0,         0, 16'h0000);
            row(0, 0, 0, 16'h0004, 16'hFFFF, 1, 32'h8000_0012, 0, 16'h0000);
        end else begin
            row(0, 0, 0, 16'h0004, 16'hFFFF, 1, 32'h8000_0012, 0, 16'h0000);
        end
        row(0, 0, 1, 16'h0000, 16'hFFFF, 0, 32'h0, 1, 16'h0004);
        row(0, 0, 0, 16'h0000, 16'hFFFF, 0, 32'h0, 0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
